// File: rtl/seg_scan_display.sv
// seg_scan_display: captures a 2-bit keyed selector's output (f) and select value (sel)
// on a synchronised load strobe and counts the captures in BCD (00..99). It drives a
// 4-digit multiplexed seven-segment display with active-low segments and anodes.
// Optional feature macro: LEADING_ZERO_BLANK_EN (darkens the tens digit while it is 0).
module seg_scan_display #(
    parameter int unsigned SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] f,
    input  logic [1:0] sel,
    input  logic       load,
    input  logic       blank,
    output logic [7:0] seg,
    output logic [3:0] an
);

    localparam int unsigned PrescW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PrescW-1:0] PrescMax = PrescW'(SCAN_DIV - 1);

    logic              q1_q, q2_q, q3_q;
    logic              ld_ev;
    logic [1:0]        cap_f_q, cap_f_d;
    logic [1:0]        cap_sel_q, cap_sel_d;
    logic [3:0]        ones_q, ones_d;
    logic [3:0]        tens_q, tens_d;
    logic [PrescW-1:0] presc_q, presc_d;
    logic [1:0]        idx_q, idx_d;
    logic [3:0]        digit;
    logic [7:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;

    // {dp,g,f,e,d,c,b,a}, active-low; dp stays off
    function automatic logic [7:0] seg_code(input logic [3:0] v);
        logic [7:0] c;
        case (v)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = 8'hFF;
        endcase
        return c;
    endfunction

    // Two-flop synchroniser for the asynchronous load level, plus one delay flop for edge detect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q1_q <= 1'b0;
            q2_q <= 1'b0;
            q3_q <= 1'b0;
        end else begin
            q1_q <= load;
            q2_q <= q1_q;
            q3_q <= q2_q;
        end
    end

    assign ld_ev = q2_q & ~q3_q;

    // Capture and BCD increment share the single-cycle load event
    always_comb begin
        cap_f_d   = cap_f_q;
        cap_sel_d = cap_sel_q;
        ones_d    = ones_q;
        tens_d    = tens_q;
        if (ld_ev) begin
            cap_f_d   = f;
            cap_sel_d = sel;
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    // Scan timing: prescaler terminal count advances the digit index modulo 4
    always_comb begin
        presc_d = presc_q + PrescW'(1);
        idx_d   = idx_q;
        if (presc_q == PrescMax) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
        end
    end

    // Digit select and output decode from the current index and data registers
    always_comb begin
        case (idx_q)
            2'd0:    digit = {2'b00, cap_f_q};
            2'd1:    digit = {2'b00, cap_sel_q};
            2'd2:    digit = ones_q;
            default: digit = tens_q;
        endcase
        an_d  = ~(4'b0001 << idx_q);
        seg_d = seg_code(digit);
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_q == 2'd3 && tens_q == 4'd0) begin
            an_d  = 4'hF;
            seg_d = 8'hFF;
        end
`endif
        if (blank) begin
            an_d  = 4'hF;
            seg_d = 8'hFF;
        end
    end

    // State and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_f_q   <= 2'd0;
            cap_sel_q <= 2'd0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            presc_q   <= '0;
            idx_q     <= 2'd0;
            seg_q     <= 8'hFF;
            an_q      <= 4'hF;
        end else begin
            cap_f_q   <= cap_f_d;
            cap_sel_q <= cap_sel_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: a SCAN_DIV=4 and a SCAN_DIV=1 instance share all inputs.
// Expected display words are pushed to a queue before each clock and popped after it.
module tb_seg_scan_display;

    logic       clk;
    logic       rst_n;
    logic [1:0] f;
    logic [1:0] sel;
    logic       load;
    logic       blank;
    logic [7:0] seg4, seg1;
    logic [3:0] an4, an1;

    int total = 0;
    int bad   = 0;
    int edges = 0;

    // Reference data model
    int         m_cnt = 0;
    logic [1:0] m_f   = 2'd0;
    logic [1:0] m_sel = 2'd0;

    logic [11:0] exp_q[$];
    string       tag_q[$];

    seg_scan_display #(.SCAN_DIV(4)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .f     (f),
        .sel   (sel),
        .load  (load),
        .blank (blank),
        .seg   (seg4),
        .an    (an4)
    );

    seg_scan_display #(.SCAN_DIV(1)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .f     (f),
        .sel   (sel),
        .load  (load),
        .blank (blank),
        .seg   (seg1),
        .an    (an1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising edges seen since reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    function automatic logic [7:0] segc(input int v);
        case (v)
            0: return 8'hC0;
            1: return 8'hF9;
            2: return 8'hA4;
            3: return 8'hB0;
            4: return 8'h99;
            5: return 8'h92;
            6: return 8'h82;
            7: return 8'hF8;
            8: return 8'h80;
            9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [11:0] exp_out(input int idx, input logic blk);
        int         v;
        logic [3:0] a;
        if (blk) return 12'hFFF;
        case (idx)
            0: v = int'(m_f);
            1: v = int'(m_sel);
            2: v = m_cnt % 10;
            default: v = m_cnt / 10;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (idx == 3 && m_cnt / 10 == 0) return 12'hFFF;
`endif
        a = 4'b0001 << idx;
        return {~a, segc(v)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Push expectations for the coming edge, advance, then pop and compare both instances
    task automatic step_chk(input string tag);
        logic [11:0] e;
        string       t;
        exp_q.push_back(exp_out((edges / 4) % 4, blank));
        exp_q.push_back(exp_out(edges % 4, blank));
        tag_q.push_back(tag);
        @(negedge clk);
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        chk({t, "/div4"}, {20'd0, an4, seg4}, {20'd0, e});
        e = exp_q.pop_front();
        chk({t, "/div1"}, {20'd0, an1, seg1}, {20'd0, e});
    endtask

    task automatic pulse(input logic [1:0] fv, input logic [1:0] sv);
        f    = fv;
        sel  = sv;
        load = 1'b1;
        cyc(3);
        load = 1'b0;
        cyc(3);
        m_f   = fv;
        m_sel = sv;
        m_cnt = (m_cnt + 1) % 100;
    endtask

    initial begin
        rst_n = 1'b0;
        f     = 2'd0;
        sel   = 2'd0;
        load  = 1'b0;
        blank = 1'b0;

        // Reset state
        cyc(3);
        chk("rst_an4", {28'd0, an4}, 32'hF);
        chk("rst_seg4", {24'd0, seg4}, 32'hFF);
        chk("rst_an1", {28'd0, an1}, 32'hF);
        chk("rst_seg1", {24'd0, seg1}, 32'hFF);

        // Release and watch the scan step E,D,B,7 and wrap
        rst_n = 1'b1;
        for (int i = 0; i < 17; i++) step_chk("scan_init");

        // Capture latency: load held 5 cycles gives exactly one capture on the 3rd edge
        f    = 2'b11;
        sel  = 2'b10;
        load = 1'b1;
        cyc(2);
        chk("lat_edge2_ones", {28'd0, dut4.ones_q}, 32'd0);
        cyc(1);
        chk("lat_edge3_ones", {28'd0, dut4.ones_q}, 32'd1);
        chk("lat_edge3_f", {30'd0, dut4.cap_f_q}, 32'd3);
        chk("lat_edge3_sel", {30'd0, dut4.cap_sel_q}, 32'd2);
        cyc(2);
        load = 1'b0;
        cyc(4);
        chk("one_capture", {28'd0, dut4.ones_q}, 32'd1);
        m_f   = 2'b11;
        m_sel = 2'b10;
        m_cnt = 1;
        for (int i = 0; i < 16; i++) step_chk("digits_after_cap");

        // BCD wrap 99 -> 00
        for (int i = 0; i < 98; i++) pulse(2'(i), 2'(i + 1));
        chk("bcd99_ones", {28'd0, dut4.ones_q}, 32'd9);
        chk("bcd99_tens", {28'd0, dut4.tens_q}, 32'd9);
        for (int i = 0; i < 16; i++) step_chk("digits_99");
        pulse(2'd1, 2'd3);
        chk("bcd00_ones", {28'd0, dut4.ones_q}, 32'd0);
        chk("bcd00_tens", {28'd0, dut4.tens_q}, 32'd0);
        for (int i = 0; i < 16; i++) step_chk("digits_00");

        // Blank during idx2; scan keeps running underneath
        for (int i = 0; i < 16 && ((edges / 4) % 4) != 2; i++) step_chk("pre_blank");
        blank = 1'b1;
        for (int i = 0; i < 3; i++) step_chk("blank_on");
        blank = 1'b0;
        for (int i = 0; i < 8; i++) step_chk("blank_off");

        // Count to 37, then async reset with load held high through release
        for (int i = 0; i < 37; i++) pulse(2'(i + 2), 2'(i));
        chk("cnt37_ones", {28'd0, dut4.ones_q}, 32'd7);
        chk("cnt37_tens", {28'd0, dut4.tens_q}, 32'd3);
        for (int i = 0; i < 16; i++) step_chk("digits_37");
        f    = 2'b01;
        sel  = 2'b11;
        load = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_an4", {28'd0, an4}, 32'hF);
        chk("async_seg4", {24'd0, seg4}, 32'hFF);
        chk("async_an1", {28'd0, an1}, 32'hF);
        chk("async_ones", {28'd0, dut4.ones_q}, 32'd0);
        chk("async_tens", {28'd0, dut4.tens_q}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(2);
        chk("rel_edge2_ones", {28'd0, dut4.ones_q}, 32'd0);
        cyc(1);
        chk("rel_edge3_ones", {28'd0, dut4.ones_q}, 32'd1);
        cyc(5);
        chk("rel_one_capture", {28'd0, dut4.ones_q}, 32'd1);
        m_f   = 2'b01;
        m_sel = 2'b11;
        m_cnt = 1;
        for (int i = 0; i < 16; i++) step_chk("digits_after_rst");
        load = 1'b0;
        cyc(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
